// File: rtl/reorder_pkg.sv
// Shared types and the even/odd split index used by the line reorder buffer
// and the DWT address generators.
package reorder_pkg;

   typedef enum logic {
      MODE_RASTER = 1'b0,
      MODE_SPLIT  = 1'b1
   } mode_t;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_t;

   // Sample index to fetch for output position rcnt: identity in raster mode,
   // even samples first then odd samples in split mode.
   function automatic int unsigned idx(input mode_t       mode,
                                       input int unsigned rcnt,
                                       input int unsigned line_len);
      int unsigned half;
      half = line_len / 2;
      if (mode == MODE_SPLIT) begin
         if (rcnt < half) return 2 * rcnt;
         return 2 * (rcnt - half) + 1;
      end
      return rcnt;
   endfunction

endpackage

// File: rtl/Bram.sv
// Simple dual-port RAM: port A write-only, port B registered read-only.
//  clk            single clock
//  ena/wea        port A enable / write enable (write when both high)
//  addra/dina     port A address / write data
//  enb            port B read enable; doutb updates only when high
//  addrb/doutb    port B address / registered read data
module Bram #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned Size      = 128,
   parameter int unsigned AddrW     = $clog2(Size)
) (
   input  logic                 clk,
   input  logic                 ena,
   input  logic                 wea,
   input  logic [AddrW-1:0]     addra,
   input  logic [DataWidth-1:0] dina,
   input  logic                 enb,
   input  logic [AddrW-1:0]     addrb,
   output logic [DataWidth-1:0] doutb
);

   logic [DataWidth-1:0] mem [Size];

   // Port A write
   always_ff @(posedge clk) begin
      if (ena && wea) mem[addra] <= dina;
   end

   // Port B registered read, held while disabled
   always_ff @(posedge clk) begin
      if (enb) doutb <= mem[addrb];
   end

endmodule

// File: rtl/bram_pingpong_reorder.sv
// Ping-pong line reorder buffer: one bank fills in raster order while the
// other drains in raster or even/odd-split order, 1 sample/clk sustained.
//  clk, rst_n           clock, async active-low reset
//  mode                 0 raster, 1 split; captured on the first sample of a line
//  in_valid/in_ready    input handshake; in_ready = write bank empty
//  in_data, in_last     input sample and producer end-of-line marker
//  out_valid/out_ready  output handshake
//  out_data, out_last   output sample, last marker on final sample of a line
//  err_len              sticky: in_last disagreed with the sample count
module bram_pingpong_reorder
   import reorder_pkg::*;
#(
   parameter int unsigned DataWidth  = 16,
   parameter int unsigned LineLength = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DataWidth-1:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DataWidth-1:0] out_data,
   output logic                 out_last,
   output logic                 err_len
);

   localparam int unsigned CntW    = $clog2(LineLength);
   localparam int unsigned AddrW   = $clog2(2 * LineLength);
   localparam int unsigned LastCnt = LineLength - 1;

   bank_state_t [1:0] bank_q, bank_d;
   mode_t       [1:0] bank_mode_q, bank_mode_d;
   logic [CntW-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d;
   logic [AddrW-1:0]  rd_addr_q, rd_addr_d;
   logic              wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
   logic              in_ready_q, in_ready_d;
   logic              iss_valid_q, iss_valid_d, iss_last_q, iss_last_d;
   logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic              err_len_q, err_len_d;

   logic              wr_fire, wr_at_end, advance, rd_issue, rd_at_end;
   logic [AddrW-1:0]  wr_addr;

   // Write side, read issue, output stage and bank bookkeeping
   always_comb begin
      bank_d      = bank_q;
      bank_mode_d = bank_mode_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      rd_addr_d   = rd_addr_q;
      wr_sel_d    = wr_sel_q;
      rd_sel_d    = rd_sel_q;
      iss_valid_d = iss_valid_q;
      iss_last_d  = iss_last_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      err_len_d   = err_len_q;

      wr_fire   = in_valid & in_ready_q;
      wr_at_end = (wcnt_q == CntW'(LastCnt));
      wr_addr   = AddrW'((wr_sel_q ? LineLength : 32'd0) + 32'(wcnt_q));

      if (wr_fire) begin
         if (wcnt_q == '0) bank_mode_d[wr_sel_q] = mode_t'(mode);
         if (in_last != wr_at_end) err_len_d = 1'b1;
         if (wr_at_end) begin
            wcnt_d           = '0;
            bank_d[wr_sel_q] = BANK_FULL;
            wr_sel_d         = ~wr_sel_q;
         end else begin
            wcnt_d = wcnt_q + CntW'(1);
         end
      end

      advance   = ~out_valid_q | out_ready;
      rd_issue  = advance & (bank_q[rd_sel_q] == BANK_FULL);
      rd_at_end = (rcnt_q == CntW'(LastCnt));

      // Issue stage holds the RAM address; the RAM read and output flags move together
      if (advance) begin
         out_valid_d = iss_valid_q;
         out_last_d  = iss_last_q;
         iss_valid_d = rd_issue;
         iss_last_d  = rd_issue & rd_at_end;
         if (rd_issue) begin
            rd_addr_d = AddrW'((rd_sel_q ? LineLength : 32'd0)
                               + idx(bank_mode_q[rd_sel_q], 32'(rcnt_q), LineLength));
            if (rd_at_end) begin
               rcnt_d           = '0;
               bank_d[rd_sel_q] = BANK_EMPTY;
               rd_sel_d         = ~rd_sel_q;
            end else begin
               rcnt_d = rcnt_q + CntW'(1);
            end
         end
      end

      in_ready_d = (bank_d[wr_sel_d] == BANK_EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]      <= BANK_EMPTY;
         bank_q[1]      <= BANK_EMPTY;
         bank_mode_q[0] <= MODE_RASTER;
         bank_mode_q[1] <= MODE_RASTER;
         wcnt_q         <= '0;
         rcnt_q         <= '0;
         rd_addr_q      <= '0;
         wr_sel_q       <= 1'b0;
         rd_sel_q       <= 1'b0;
         in_ready_q     <= 1'b0;
         iss_valid_q    <= 1'b0;
         iss_last_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         out_last_q     <= 1'b0;
         err_len_q      <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         bank_mode_q <= bank_mode_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         rd_addr_q   <= rd_addr_d;
         wr_sel_q    <= wr_sel_d;
         rd_sel_q    <= rd_sel_d;
         in_ready_q  <= in_ready_d;
         iss_valid_q <= iss_valid_d;
         iss_last_q  <= iss_last_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         err_len_q   <= err_len_d;
      end
   end

   Bram #(
      .DataWidth (DataWidth),
      .Size      (2 * LineLength)
   ) u_bram (
      .clk   (clk),
      .ena   (wr_fire),
      .wea   (wr_fire),
      .addra (wr_addr),
      .dina  (in_data),
      .enb   (advance),
      .addrb (rd_addr_q),
      .doutb (out_data)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign err_len   = err_len_q;

endmodule

// File: tb/tb_bram_pingpong_reorder.sv
// Randomized bench for bram_pingpong_reorder against a line-level reference model.
module tb_bram_pingpong_reorder;

   localparam int DW = 16;
   localparam int L  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mode = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, out_valid, out_last, err_len, out_ready;
   logic [DW-1:0] out_data;

   logic rand_rdy = 1'b0;
   logic rnd_rdy  = 1'b1;
   logic fix_rdy  = 1'b1;
   assign out_ready = rand_rdy ? rnd_rdy : fix_rdy;

   always #5 clk = ~clk;

   bram_pingpong_reorder #(.DataWidth(DW), .LineLength(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .err_len   (err_len)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   logic [DW:0]   exp_q[$];
   logic [DW-1:0] line_buf[$];
   logic          line_mode;
   logic          exp_err = 1'b0;
   int            cyc = 0;
   int            last_in_cyc = 0, first_valid_cyc = 0;
   bit            first_seen = 0;
   int            out_seen = 0, stall_in_cnt = 0, bubble_cnt = 0, bubble_base = 0;
   bit            bubble_en = 0;
   bit            hold_pend = 0;
   logic [DW-1:0] hold_data;
   logic          hold_last;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rnd_rdy = ($urandom_range(0, 9) >= 3);
   end

   // Monitor: samples at negedge, the handshakes then complete on the next posedge
   always @(negedge clk) begin
      logic [DW:0] e;
      if (!rst_n) begin
         exp_q.delete();
         line_buf.delete();
         exp_err    = 1'b0;
         hold_pend  = 0;
         first_seen = 0;
      end else begin
         if (hold_pend) begin
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_data", 32'(out_data), 32'(hold_data));
            check_eq("hold_last", 32'(out_last), 32'(hold_last));
         end
         hold_pend = out_valid && !out_ready;
         hold_data = out_data;
         hold_last = out_last;
         if (out_valid && !first_seen) begin
            first_seen      = 1;
            first_valid_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("out_unexpected", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("out_data", 32'(out_data), 32'(e[DW-1:0]));
               check_eq("out_last", 32'(out_last), 32'(e[DW]));
               out_seen++;
            end
         end else if (bubble_en && !out_valid && out_seen > bubble_base && exp_q.size() > 0) begin
            bubble_cnt++;
         end
         if (in_valid && !in_ready) stall_in_cnt++;
         if (in_valid && in_ready) begin
            if (line_buf.size() == 0) line_mode = mode;
            if (in_last != (line_buf.size() == L - 1)) exp_err = 1'b1;
            line_buf.push_back(in_data);
            if (line_buf.size() == L) begin
               last_in_cyc = cyc;
               if (line_mode) begin
                  for (int j = 0; j < L; j += 2) exp_q.push_back({1'b0, line_buf[j]});
                  for (int j = 1; j < L; j += 2) exp_q.push_back({(j == L - 1), line_buf[j]});
               end else begin
                  for (int j = 0; j < L; j++) exp_q.push_back({(j == L - 1), line_buf[j]});
               end
               line_buf.delete();
            end
         end
      end
   end

   task automatic wait_hs();
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check_eq("in_hs_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Drives n samples of a line; mode is randomized after the first sample
   task automatic send_line(input logic m, input int n, input int bad_last,
                            input bit gaps, input bit rnd);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         mode     = (i == 0) ? m : 1'($urandom_range(0, 1));
         in_data  = rnd ? DW'($urandom) : DW'(i);
         in_last  = (bad_last >= 0) ? (i == bad_last) : (i == L - 1);
         wait_hs();
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      check_eq("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_last", 32'(out_last), 32'd0);
      check_eq("rst_err_len", 32'(err_len), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

      // 1) Raster line with latency check
      base = out_seen;
      send_line(1'b0, L, -1, 0, 0);
      idle();
      wait_drain();
      check_eq("t1_count", 32'(out_seen - base), 32'(L));
      check_eq("t1_latency", 32'(first_valid_cyc - last_in_cyc), 32'd3);

      // 2) Split line
      base = out_seen;
      send_line(1'b1, L, -1, 0, 0);
      idle();
      wait_drain();
      check_eq("t2_count", 32'(out_seen - base), 32'(L));

      // 3) Back-to-back lines, modes 0,1,1,0
      base         = out_seen;
      stall_in_cnt = 0;
      bubble_cnt   = 0;
      bubble_base  = out_seen;
      bubble_en    = 1;
      send_line(1'b0, L, -1, 0, 1);
      send_line(1'b1, L, -1, 0, 1);
      send_line(1'b1, L, -1, 0, 1);
      send_line(1'b0, L, -1, 0, 1);
      idle();
      wait_drain();
      bubble_en = 0;
      check_eq("t3_count", 32'(out_seen - base), 32'(4 * L));
      check_eq("t3_in_stalls", 32'(stall_in_cnt), 32'd0);
      check_eq("t3_bubbles", 32'(bubble_cnt), 32'd0);

      // 4) Random backpressure, random modes and input gaps
      base     = out_seen;
      rand_rdy = 1'b1;
      for (int k = 0; k < 6; k++) send_line(1'($urandom_range(0, 1)), L, -1, 1, 1);
      idle();
      wait_drain();
      rand_rdy = 1'b0;
      check_eq("t4_count", 32'(out_seen - base), 32'(6 * L));
      // Both banks full with the consumer stalled
      fix_rdy = 1'b0;
      send_line(1'b0, L, -1, 0, 1);
      send_line(1'b1, L, -1, 0, 1);
      idle();
      @(negedge clk);
      check_eq("t4_full_in_ready", 32'(in_ready), 32'd0);
      repeat (5) @(negedge clk);
      check_eq("t4_full_in_ready_hold", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      fix_rdy = 1'b1;
      wait_drain();
      check_eq("t4_err_clear", 32'(err_len), 32'd0);

      // 5) Framing error: in_last on sample 5
      base = out_seen;
      send_line(1'b0, L, 5, 0, 1);
      idle();
      @(negedge clk);
      check_eq("t5_err_set", 32'(err_len), 32'd1);
      send_line(1'b1, L, -1, 0, 1);
      idle();
      wait_drain();
      check_eq("t5_err_sticky", 32'(err_len), 32'(exp_err));
      check_eq("t5_count", 32'(out_seen - base), 32'(2 * L));

      // 6) Reset mid-line while a previous line drains
      send_line(1'b1, L, -1, 0, 1);
      send_line(1'b0, 3, -1, 0, 1);
      idle();
      check_eq("t6_pre_rst_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("t6_rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("t6_rst_err", 32'(err_len), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base  = out_seen;
      repeat (20) @(posedge clk);
      #1;
      check_eq("t6_no_output", 32'(out_seen - base), 32'd0);
      check_eq("t6_in_ready", 32'(in_ready), 32'd1);
      send_line(1'b1, L, -1, 0, 1);
      idle();
      wait_drain();
      check_eq("t6_count", 32'(out_seen - base), 32'(L));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
